// File: rtl/qspi_cmd_router.sv
// qspi_cmd_router: SPI flash-command front end that routes reads to one of
// NUM_RAMS PSRAM channels, answers RDID/RDSR locally, tracks WEL/WIP and
// buffers page-program payload bytes in a FIFO for the downstream controller.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | chip select high (or waiting for a fresh CS fall)
// S_CMD    | shifting in the 8-bit opcode, all RAM selects asserted
// S_ADDR   | shifting in 24/32 address bits
// S_DUMMY  | FAST_READ dummy cycles
// S_TX     | driving MISO from RAM, JEDEC ID or status register
// S_RX     | page-program payload into the write FIFO
// S_IGNORE | remaining bits of the frame are counted but not acted on
module qspi_cmd_router #(
  parameter int          NUM_RAMS      = 2,
  parameter logic [23:0] JEDEC_ID      = 24'hC22018,
  parameter int          WBUF_DEPTH    = 256,
  parameter bit          ADDR4_DEFAULT = 1'b0,
  parameter int          FAST_DUMMY    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_clk,
  input  logic                spi_cs,
  input  logic                spi_di,
  output logic                spi_do,
  output logic                spi_do_enable,
  output logic [NUM_RAMS-1:0] ram_cs,
  input  logic [NUM_RAMS-1:0] ram_di,
  output logic [7:0]          cmd_out,
  output logic [31:0]         addr_out,
  output logic [11:0]         len_out,
  output logic                cmd_strobe,
  output logic [7:0]          sr,
  input  logic [7:0]          sr_in,
  input  logic                sr_in_strobe,
  output logic [7:0]          wbuf_data,
  output logic                wbuf_valid,
  input  logic                wbuf_ready,
  output logic                wbuf_overflow,
  output logic                addr4
);

  localparam int SEL_W = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam int WB_AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [NUM_RAMS-1:0] RAM_ONE  = NUM_RAMS'(1);
  localparam logic [WB_AW:0]      FULL_CNT = WBUF_DEPTH[WB_AW:0];

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_TX, S_RX, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {TX_RAM, TX_ID, TX_SR} tx_src_t;

  // [0] metastable stage, [1] synchronised, [2] previous synchronised value
  logic [2:0] r_sclk_pipe;
  logic [2:0] r_cs_pipe;
  logic [1:0] r_di_pipe;

  state_t        r_state;
  tx_src_t       r_tx_src;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic [5:0]    r_addr_cnt;
  logic [31:0]   r_addr;
  logic          r_addr_done;
  logic [7:0]    r_dummy_cnt;
  logic [1:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic [7:0]    r_opcode;
  logic          r_op_done;
  logic          r_wel_at_op;
  logic [11:0]   r_len;
  logic [SEL_W-1:0] r_sel;
  logic          r_spi_do;
  logic          r_spi_do_en;
  logic [NUM_RAMS-1:0] r_ram_cs;
  logic [7:0]    r_sr;
  logic          r_addr4;
  logic [7:0]    r_cmd_out;
  logic [31:0]   r_addr_out;
  logic [11:0]   r_len_out;
  logic          r_cmd_strobe;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_ovf_clr;

  logic [7:0]       r_mem [WBUF_DEPTH];
  logic [WB_AW-1:0] r_wr_ptr;
  logic [WB_AW-1:0] r_rd_ptr;
  logic [WB_AW:0]   r_count;
  logic             r_overflow;

  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_cs_rise;
  logic             w_cs_fall;
  logic             w_cs_high;
  logic             w_di;
  logic [7:0]       w_byte_next;
  logic             w_byte_done;
  logic [5:0]       w_addr_msb;
  logic [4:0]       w_addr_idx;
  logic [31:0]      w_addr_next;
  logic [SEL_W-1:0] w_sel_next;
  logic [7:0]       w_tx_byte;
  logic [11:0]      w_len_inc;
  logic             w_is_read_op;
  logic             w_reportable;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;

  assign w_sclk_rise  = r_sclk_pipe[1] & ~r_sclk_pipe[2];
  assign w_sclk_fall  = ~r_sclk_pipe[1] & r_sclk_pipe[2];
  assign w_cs_rise    = r_cs_pipe[1] & ~r_cs_pipe[2];
  assign w_cs_fall    = ~r_cs_pipe[1] & r_cs_pipe[2];
  assign w_cs_high    = r_cs_pipe[1];
  assign w_di         = r_di_pipe[1];
  assign w_byte_next  = {r_shift, w_di};
  assign w_byte_done  = (r_bit_cnt == 3'd7);
  assign w_addr_msb   = r_addr4 ? 6'd31 : 6'd23;
  assign w_addr_idx   = w_addr_msb[4:0] - r_addr_cnt[4:0];
  assign w_len_inc    = (r_len == 12'hFFF) ? r_len : r_len + 12'd1;
  assign w_is_read_op = (r_opcode == 8'h03) || (r_opcode == 8'h0B);
  assign w_reportable = r_op_done && (r_opcode != 8'h9F) && (r_opcode != 8'h05) &&
                        (r_opcode != 8'h06) && (r_opcode != 8'h04);

  // Address register as it will look once the current bit is captured
  always_comb begin
    w_addr_next = r_addr;
    w_addr_next[w_addr_idx] = w_di;
  end

  // Channel select from the top address bits; a single channel is always channel 0
  always_comb begin
    w_sel_next = r_addr4 ? w_addr_next[31 -: SEL_W] : w_addr_next[23 -: SEL_W];
    if (NUM_RAMS == 1) w_sel_next = '0;
  end

  // Byte to serialise for locally answered reads
  always_comb begin
    w_tx_byte = 8'h00;
    if (r_tx_src == TX_SR) begin
      w_tx_byte = r_sr;
    end else begin
      case (r_tx_idx)
        2'd0:    w_tx_byte = JEDEC_ID[23:16];
        2'd1:    w_tx_byte = JEDEC_ID[15:8];
        2'd2:    w_tx_byte = JEDEC_ID[7:0];
        default: w_tx_byte = 8'h00;
      endcase
    end
  end

  // Two-flop synchronisers plus one history stage for edge detection.
  // CS history resets low so a frame already in progress at reset release
  // is not mistaken for a fresh CS fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_pipe <= '0;
      r_cs_pipe   <= '0;
      r_di_pipe   <= '0;
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[1:0], spi_clk};
      r_cs_pipe   <= {r_cs_pipe[1:0], spi_cs};
      r_di_pipe   <= {r_di_pipe[0], spi_di};
    end
  end

  // Main sequencing FSM: decode, address capture, MISO drive and end-of-frame reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tx_src     <= TX_RAM;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_addr_cnt   <= '0;
      r_addr       <= '0;
      r_addr_done  <= 1'b0;
      r_dummy_cnt  <= '0;
      r_tx_idx     <= '0;
      r_tx_shift   <= '0;
      r_opcode     <= '0;
      r_op_done    <= 1'b0;
      r_wel_at_op  <= 1'b0;
      r_len        <= '0;
      r_sel        <= '0;
      r_spi_do     <= 1'b0;
      r_spi_do_en  <= 1'b0;
      r_ram_cs     <= '1;
      r_sr         <= '0;
      r_addr4      <= ADDR4_DEFAULT;
      r_cmd_out    <= '0;
      r_addr_out   <= '0;
      r_len_out    <= '0;
      r_cmd_strobe <= 1'b0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_ovf_clr    <= 1'b0;
    end else begin
      r_cmd_strobe <= 1'b0;
      r_push       <= 1'b0;
      r_ovf_clr    <= 1'b0;
      if (w_cs_high) begin
        r_state     <= S_IDLE;
        r_ram_cs    <= '1;
        r_spi_do    <= 1'b0;
        r_spi_do_en <= 1'b0;
        if (w_cs_rise && r_state != S_IDLE) begin
          if (w_reportable) begin
            r_cmd_strobe <= 1'b1;
            r_cmd_out    <= r_opcode;
            r_addr_out   <= r_addr_done ? r_addr : 32'h0;
            r_len_out    <= r_len;
          end
          if (r_op_done && r_wel_at_op && r_addr_done &&
              (r_opcode == 8'h02 || r_opcode == 8'h20)) begin
            r_sr[0] <= 1'b1;
            r_sr[1] <= 1'b0;
          end
        end
      end else if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_state     <= S_CMD;
          r_tx_src    <= TX_RAM;
          r_bit_cnt   <= '0;
          r_addr_cnt  <= '0;
          r_addr      <= '0;
          r_addr_done <= 1'b0;
          r_dummy_cnt <= '0;
          r_tx_idx    <= '0;
          r_op_done   <= 1'b0;
          r_len       <= '0;
          r_ram_cs    <= '0;
        end
      end else begin
        if (w_sclk_rise) begin
          r_shift   <= w_byte_next[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) r_len <= w_len_inc;
          case (r_state)
            S_CMD: begin
              if (w_byte_done) begin
                r_opcode    <= w_byte_next;
                r_op_done   <= 1'b1;
                r_wel_at_op <= r_sr[1];
                r_ram_cs    <= '1;
                r_state     <= S_IGNORE;
                case (w_byte_next)
                  8'h9F: begin
                    r_state     <= S_TX;
                    r_tx_src    <= TX_ID;
                    r_spi_do_en <= 1'b1;
                  end
                  8'h05: begin
                    r_state     <= S_TX;
                    r_tx_src    <= TX_SR;
                    r_spi_do_en <= 1'b1;
                  end
                  8'h06: r_sr[1] <= 1'b1;
                  8'h04: r_sr[1] <= 1'b0;
                  8'hB7: r_addr4 <= 1'b1;
                  8'hE9: r_addr4 <= 1'b0;
                  8'h03, 8'h0B: begin
                    r_state  <= S_ADDR;
                    r_ram_cs <= '0;
                  end
                  8'h02: begin
                    r_state <= S_ADDR;
                    if (r_sr[1]) r_ovf_clr <= 1'b1;
                  end
                  8'h20: r_state <= S_ADDR;
                  default: ;
                endcase
              end
            end
            S_ADDR: begin
              r_addr     <= w_addr_next;
              r_addr_cnt <= r_addr_cnt + 6'd1;
              if (r_addr_cnt == 6'd7 && w_is_read_op) begin
                r_sel    <= w_sel_next;
                r_ram_cs <= ~(RAM_ONE << w_sel_next);
              end
              if (r_addr_cnt == w_addr_msb) begin
                r_addr_done <= 1'b1;
                case (r_opcode)
                  8'h03: begin
                    r_state     <= S_TX;
                    r_tx_src    <= TX_RAM;
                    r_spi_do_en <= 1'b1;
                  end
                  8'h0B: begin
                    r_tx_src <= TX_RAM;
                    if (FAST_DUMMY == 0) begin
                      r_state     <= S_TX;
                      r_spi_do_en <= 1'b1;
                    end else begin
                      r_state <= S_DUMMY;
                    end
                  end
                  8'h02:   r_state <= S_RX;
                  default: r_state <= S_IGNORE;
                endcase
              end
            end
            S_DUMMY: begin
              r_dummy_cnt <= r_dummy_cnt + 8'd1;
              if (r_dummy_cnt == 8'(FAST_DUMMY - 1)) begin
                r_state     <= S_TX;
                r_spi_do_en <= 1'b1;
              end
            end
            S_TX: begin
              if (w_byte_done && r_tx_idx != 2'd3) r_tx_idx <= r_tx_idx + 2'd1;
            end
            S_RX: begin
              if (w_byte_done && r_wel_at_op) begin
                r_push      <= 1'b1;
                r_push_data <= w_byte_next;
              end
            end
            default: ;
          endcase
        end
        // Local responses: load a fresh byte on the first fall of each byte
        if (w_sclk_fall && r_state == S_TX && r_tx_src != TX_RAM) begin
          if (r_bit_cnt == 3'd0) begin
            r_spi_do   <= w_tx_byte[7];
            r_tx_shift <= {w_tx_byte[6:0], 1'b0};
          end else begin
            r_spi_do   <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
        if (r_state == S_TX && r_tx_src == TX_RAM) r_spi_do <= ram_di[r_sel];
      end
      // Controller writes to the status register take precedence
      if (sr_in_strobe) r_sr <= sr_in;
    end
  end

  assign w_pop    = wbuf_ready && (r_count != '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_accept = r_push && (!w_full || w_pop);

  // Write-FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_ovf_clr)                r_overflow <= 1'b0;
      else if (r_push && !w_accept) r_overflow <= 1'b1;
    end
  end

  // Write-FIFO storage
  always_ff @(posedge clk) begin
    if (!reset && w_accept) r_mem[r_wr_ptr] <= r_push_data;
  end

  assign spi_do        = r_spi_do;
  assign spi_do_enable = r_spi_do_en;
  assign ram_cs        = r_ram_cs;
  assign cmd_out       = r_cmd_out;
  assign addr_out      = r_addr_out;
  assign len_out       = r_len_out;
  assign cmd_strobe    = r_cmd_strobe;
  assign sr            = r_sr;
  assign addr4         = r_addr4;
  assign wbuf_data     = r_mem[r_rd_ptr];
  assign wbuf_valid    = (r_count != '0);
  assign wbuf_overflow = r_overflow;

endmodule

// File: tb/tb_qspi_cmd_router.sv
// Directed bench for qspi_cmd_router: drives SPI frames bit by bit and checks
// outputs against hand-computed values.
module tb_qspi_cmd_router;

  localparam int HALF  = 5;
  localparam int NRAM  = 4;
  localparam int DEPTH = 16;

  logic            clk;
  logic            reset;
  logic            spi_clk;
  logic            spi_cs;
  logic            spi_di;
  logic            spi_do;
  logic            spi_do_enable;
  logic [NRAM-1:0] ram_cs;
  logic [NRAM-1:0] ram_di;
  logic [7:0]      cmd_out;
  logic [31:0]     addr_out;
  logic [11:0]     len_out;
  logic            cmd_strobe;
  logic [7:0]      sr;
  logic [7:0]      sr_in;
  logic            sr_in_strobe;
  logic [7:0]      wbuf_data;
  logic            wbuf_valid;
  logic            wbuf_ready;
  logic            wbuf_overflow;
  logic            addr4;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  qspi_cmd_router #(
    .NUM_RAMS(NRAM),
    .WBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_di(spi_di),
    .spi_do(spi_do), .spi_do_enable(spi_do_enable),
    .ram_cs(ram_cs), .ram_di(ram_di),
    .cmd_out(cmd_out), .addr_out(addr_out), .len_out(len_out), .cmd_strobe(cmd_strobe),
    .sr(sr), .sr_in(sr_in), .sr_in_strobe(sr_in_strobe),
    .wbuf_data(wbuf_data), .wbuf_valid(wbuf_valid), .wbuf_ready(wbuf_ready),
    .wbuf_overflow(wbuf_overflow), .addr4(addr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic miso);
    spi_clk = 1'b0;
    spi_di  = b;
    repeat (HALF) @(negedge clk);
    miso    = spi_do;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx = {rx[6:0], b};
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    logic       b;
    logic [7:0] op;
    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_di = 1'b0;
    ram_di = '0; sr_in = 8'h00; sr_in_strobe = 1'b0; wbuf_ready = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_spi_do", 32'(spi_do), 32'h0);
    chk("rst_do_en", 32'(spi_do_enable), 32'h0);
    chk("rst_ram_cs", 32'(ram_cs), 32'hF);
    chk("rst_sr", 32'(sr), 32'h00);
    chk("rst_addr4", 32'(addr4), 32'h0);
    chk("rst_valid", 32'(wbuf_valid), 32'h0);
    chk("rst_ovf", 32'(wbuf_overflow), 32'h0);
    chk("rst_cmd", 32'(cmd_out), 32'h0);
    chk("rst_addr", addr_out, 32'h0);
    chk("rst_len", 32'(len_out), 32'h0);
    chk("rst_strobe", 32'(strobe_cnt), 32'(exp_strobes));

    // RDID
    cs_low();
    spi_byte(8'h9F, rx);
    chk("rdid_ram_cs", 32'(ram_cs), 32'hF);
    chk("rdid_en", 32'(spi_do_enable), 32'h1);
    spi_byte(8'h00, rx); chk("rdid_b0", 32'(rx), 32'hC2);
    spi_byte(8'h00, rx); chk("rdid_b1", 32'(rx), 32'h20);
    spi_byte(8'h00, rx); chk("rdid_b2", 32'(rx), 32'h18);
    spi_byte(8'h00, rx); chk("rdid_b3", 32'(rx), 32'h00);
    cs_high();
    chk("rdid_no_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("rdid_en_idle", 32'(spi_do_enable), 32'h0);

    // READ 03 80 12 34, channel 2
    cs_low();
    spi_byte(8'h03, rx);
    chk("rd_cs_all", 32'(ram_cs), 32'h0);
    spi_byte(8'h80, rx);
    chk("rd_cs_sel", 32'(ram_cs), 32'hB);
    spi_byte(8'h12, rx);
    spi_byte(8'h34, rx);
    chk("rd_en", 32'(spi_do_enable), 32'h1);
    ram_di = 4'b0100;
    repeat (2) @(negedge clk);
    chk("rd_track1", 32'(spi_do), 32'h1);
    ram_di = 4'b1011;
    repeat (2) @(negedge clk);
    chk("rd_track0", 32'(spi_do), 32'h0);
    ram_di = 4'b0100;
    spi_byte(8'h00, rx); chk("rd_data_ff", 32'(rx), 32'hFF);
    ram_di = 4'b1011;
    spi_byte(8'h00, rx); chk("rd_data_00", 32'(rx), 32'h00);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    cs_high();
    exp_strobes++;
    chk("rd_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("rd_cmd", 32'(cmd_out), 32'h03);
    chk("rd_addr", addr_out, 32'h00801234);
    chk("rd_len", 32'(len_out), 32'd8);
    chk("rd_cs_idle", 32'(ram_cs), 32'hF);

    // EN4B then FAST_READ with 32-bit address
    cs_low(); spi_byte(8'hB7, rx); cs_high();
    exp_strobes++;
    chk("b7_addr4", 32'(addr4), 32'h1);
    chk("b7_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("b7_cmd", 32'(cmd_out), 32'hB7);
    chk("b7_len", 32'(len_out), 32'd1);
    cs_low();
    spi_byte(8'h0B, rx);
    spi_byte(8'h40, rx);
    chk("fr_cs_sel", 32'(ram_cs), 32'hD);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    chk("fr_dummy_en", 32'(spi_do_enable), 32'h0);
    spi_byte(8'h00, rx);
    chk("fr_tx_en", 32'(spi_do_enable), 32'h1);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    cs_high();
    exp_strobes++;
    chk("fr_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("fr_cmd", 32'(cmd_out), 32'h0B);
    chk("fr_addr", addr_out, 32'h40000010);
    chk("fr_len", 32'(len_out), 32'd8);
    cs_low(); spi_byte(8'hE9, rx); cs_high();
    exp_strobes++;
    chk("e9_addr4", 32'(addr4), 32'h0);

    // WREN then page program overflowing the FIFO
    cs_low(); spi_byte(8'h06, rx); cs_high();
    chk("wren_sr", 32'(sr), 32'h02);
    chk("wren_no_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    cs_low();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h01, rx); spi_byte(8'h00, rx);
    for (int i = 1; i <= DEPTH + 1; i++) spi_byte(8'(i), rx);
    cs_high();
    exp_strobes++;
    chk("pp_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("pp_cmd", 32'(cmd_out), 32'h02);
    chk("pp_addr", addr_out, 32'h00000100);
    chk("pp_len", 32'(len_out), 32'd21);
    chk("pp_sr", 32'(sr), 32'h01);
    chk("pp_ovf", 32'(wbuf_overflow), 32'h1);
    chk("pp_valid", 32'(wbuf_valid), 32'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("pp_fifo_data", 32'(wbuf_data), 32'(i));
      wbuf_ready = 1'b1;
      @(negedge clk);
      wbuf_ready = 1'b0;
    end
    chk("pp_fifo_empty", 32'(wbuf_valid), 32'h0);

    // Page program without WREN
    cs_low();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h02, rx); spi_byte(8'h00, rx);
    spi_byte(8'h55, rx); spi_byte(8'hAA, rx);
    cs_high();
    exp_strobes++;
    chk("nw_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("nw_len", 32'(len_out), 32'd6);
    chk("nw_addr", addr_out, 32'h00000200);
    chk("nw_valid", 32'(wbuf_valid), 32'h0);
    chk("nw_sr", 32'(sr), 32'h01);

    // sr_in_strobe coincident with the WREN decode cycle
    sr_in = 8'hA4;
    op = 8'h06;
    cs_low();
    for (int i = 7; i >= 1; i--) spi_bit(op[i], b);
    spi_clk = 1'b0;
    spi_di  = op[0];
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sr_in_strobe = 1'b1;
    @(negedge clk);
    sr_in_strobe = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    cs_high();
    chk("srin_override", 32'(sr), 32'hA4);

    // Partial address after WREN: reported, no push, no status change
    cs_low(); spi_byte(8'h06, rx); cs_high();
    chk("wren2_sr", 32'(sr), 32'hA6);
    cs_low();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    cs_high();
    exp_strobes++;
    chk("part_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("part_len", 32'(len_out), 32'd1);
    chk("part_addr", addr_out, 32'h0);
    chk("part_cmd", 32'(cmd_out), 32'h02);
    chk("part_sr", 32'(sr), 32'hA6);
    chk("part_valid", 32'(wbuf_valid), 32'h0);
    chk("part_ovf_clr", 32'(wbuf_overflow), 32'h0);
    chk("part_en", 32'(spi_do_enable), 32'h0);

    // Reset in the middle of a page program
    cs_low();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) spi_bit(1'b0, b);
    spi_byte(8'hAA, rx);
    spi_byte(8'hBB, rx);
    chk("mid_rst_en", 32'(spi_do_enable), 32'h0);
    chk("mid_rst_ram_cs", 32'(ram_cs), 32'hF);
    cs_high();
    chk("mid_rst_strobe", 32'(strobe_cnt), 32'(exp_strobes));
    chk("mid_rst_valid", 32'(wbuf_valid), 32'h0);
    chk("mid_rst_sr", 32'(sr), 32'h00);
    chk("mid_rst_cmd", 32'(cmd_out), 32'h00);
    chk("mid_rst_len", 32'(len_out), 32'h0);

    // Fresh frame after the aborted one
    cs_low();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    chk("recover_rdid", 32'(rx), 32'hC2);
    cs_high();
    chk("recover_no_strobe", 32'(strobe_cnt), 32'(exp_strobes));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
